id_ex_pipe: RTL and testbench
=============================

# id_ex_pipe

Parametrised ID→EX pipeline register with a valid/ready handshake, a one-entry skid buffer, synchronous flush and a saturating back-pressure counter. It sits between the decode stage and the execute stage of the MIPS core. It carries ALU select/op, both operands, destination register and write enable. It lets EX stall and lets the hazard/branch unit squash the in-flight instruction.

## Interface
Parameters:
- ALUSEL_W, default 3: width of alusel field
- ALUOP_W, default 8: width of aluop field
- DATA_W, default 32: width of each operand
- REGADDR_W, default 5: width of destination register address
- SKID, default 1: 1 = skid slot present (registered id_ready); 0 = no skid slot (id_ready combinational)
- CNT_W, default 16: width of stall counter

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  synchronous squash of all held entries
- id_valid  in  1  ID presents an instruction
- id_ready  out  1  block can accept this cycle
- id_alusel, id_aluop, id_reg1, id_reg2, id_wd  in  ALUSEL_W / ALUOP_W / DATA_W / DATA_W / REGADDR_W  payload fields
- id_wreg  in  1  payload write-enable
- ex_valid  out  1  output slot holds a live instruction
- ex_ready  in  1  EX consumes this cycle
- ex_alusel, ex_aluop, ex_reg1, ex_reg2, ex_wd  out  same widths  output payload
- ex_wreg  out  1  write-enable, forced 0 whenever ex_valid=0
- stall_cnt  out  CNT_W  cycles with ex_valid=1 and ex_ready=0, saturating

## Operation
- Storage: main slot (drives ex_*) and skid slot (SKID=1 only), each with a valid bit.
- accept = id_valid & id_ready; drain = ex_valid & ex_ready.
- States, derived from the valid bits: EMPTY (none), ONE (main), FULL (main+skid).
- EMPTY: accept → ONE, main←input.
- ONE, accept & drain → ONE, main←input.
- ONE, drain only → EMPTY.
- ONE, accept only → FULL, skid←input.
- ONE, neither → hold.
- FULL: id_ready=0. drain → ONE, main←skid. Otherwise hold.
- SKID=1: id_ready = !skid_valid (pure register output).
- SKID=0: FULL unreachable; id_ready = !main_valid | ex_ready.
- flush=1: next state EMPTY. Both payloads are zeroed and same-cycle accept is discarded. Flush overrides all transitions. id_ready still reflects the pre-flush state that cycle.
- Payload: when main goes EMPTY via drain, main payload fields hold their values; ex_wreg is masked to 0.
- stall_cnt increments when ex_valid & !ex_ready and sticks at 2^CNT_W−1. It is unaffected by flush and cleared only by rst.

## Timing
- Reset (rst=0, asynchronous) sets these outputs:
  - ex_valid=0, ex_wreg=0
  - ex_alusel/ex_aluop/ex_reg1/ex_reg2/ex_wd = 0
  - stall_cnt=0
  - skid empty, so id_ready=1
- Deassertion is sampled at the next clk edge; the first accept is possible on the first edge with rst=1.
- Latency: accepted on edge N → ex_valid=1 with that payload after edge N.
- Throughput: 1 instruction/cycle while ex_ready=1.
- Back-pressure, SKID=1: ex_ready falls in cycle N with the block in ONE. The beat accepted at edge N goes to skid, and id_ready=0 from cycle N+1. The first cycle with ex_ready=1 drains main, and skid moves to main at that edge. id_ready returns to 1 the cycle after.
- No instruction is lost or duplicated under any ex_ready pattern.
- Order is strictly FIFO: main before skid.

## Test plan
- Streaming: 8 back-to-back instructions (reg1=0x10+i, wd=i, wreg=1), ex_ready=1 → each appears on ex_* exactly 1 cycle after accept, in order; ex_valid continuous; stall_cnt stays 0.
- Skid: stream with ex_ready=0 for cycles 3–5 → exactly one extra beat accepted; id_ready=0 for cycles 4–6; all 8 instructions emerge in order; stall_cnt=3.
- Flush in FULL with id_valid=1 → next cycle ex_valid=0, ex_wreg=0, payload 0, id_ready=1. Flushed and concurrent instructions never appear.
- Async reset mid-stream: rst low between edges → outputs zero immediately, without waiting for a clk edge. After release, the next accepted instruction emerges correctly.
- SKID=0 build, ex_ready toggling 1/0 → id_ready equals !ex_valid | ex_ready combinationally; no beat lost.
- CNT_W=4, ex_ready held 0 for 20 cycles with ex_valid=1 → stall_cnt saturates at 15.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ID->EX pipeline register: valid/ready handshake, optional one-entry skid slot,
// synchronous flush and a saturating back-pressure (stall) counter.
module id_ex_pipe #(
   parameter int ALUSEL_W  = 3,
   parameter int ALUOP_W   = 8,
   parameter int DATA_W    = 32,
   parameter int REGADDR_W = 5,
   parameter int SKID      = 1,
   parameter int CNT_W     = 16
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 id_valid,
   output logic                 id_ready,
   input  logic [ALUSEL_W-1:0]  id_alusel,
   input  logic [ALUOP_W-1:0]   id_aluop,
   input  logic [DATA_W-1:0]    id_reg1,
   input  logic [DATA_W-1:0]    id_reg2,
   input  logic [REGADDR_W-1:0] id_wd,
   input  logic                 id_wreg,
   output logic                 ex_valid,
   input  logic                 ex_ready,
   output logic [ALUSEL_W-1:0]  ex_alusel,
   output logic [ALUOP_W-1:0]   ex_aluop,
   output logic [DATA_W-1:0]    ex_reg1,
   output logic [DATA_W-1:0]    ex_reg2,
   output logic [REGADDR_W-1:0] ex_wd,
   output logic                 ex_wreg,
   output logic [CNT_W-1:0]     stall_cnt
);

   typedef struct packed {
      logic [ALUSEL_W-1:0]  alusel;
      logic [ALUOP_W-1:0]   aluop;
      logic [DATA_W-1:0]    reg1;
      logic [DATA_W-1:0]    reg2;
      logic [REGADDR_W-1:0] wd;
      logic                 wreg;
   } payload_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

   payload_t         in_pl;
   payload_t         main_q, main_d;
   payload_t         skid_q, skid_d;
   logic             main_valid_q, main_valid_d;
   logic             skid_valid_q, skid_valid_d;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic             accept;
   logic             drain;
   state_t           state;

   assign in_pl = '{alusel: id_alusel, aluop: id_aluop, reg1: id_reg1,
                    reg2: id_reg2, wd: id_wd, wreg: id_wreg};

   // With a skid slot id_ready comes straight from a flop, breaking the
   // combinational ready path from EX back to ID.
   generate
      if (SKID != 0) begin : g_skid
         assign id_ready = !skid_valid_q;
      end else begin : g_no_skid
         assign id_ready = !main_valid_q | ex_ready;
      end
   endgenerate

   assign accept = id_valid & id_ready;
   assign drain  = main_valid_q & ex_ready;

   always_comb begin
      state = EMPTY;
      if (main_valid_q) state = skid_valid_q ? FULL : ONE;
   end

   // NOTE: every always_comb output gets a default first, so no path can infer a latch.
   always_comb begin
      main_valid_d = main_valid_q;
      skid_valid_d = skid_valid_q;
      main_d       = main_q;
      skid_d       = skid_q;
      if (flush) begin
         main_valid_d = 1'b0;
         skid_valid_d = 1'b0;
         main_d       = '0;
         skid_d       = '0;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  main_valid_d = 1'b1;
                  main_d       = in_pl;
               end
            end
            ONE: begin
               if (drain && accept) begin
                  main_d = in_pl;
               end else if (drain) begin
                  // Payload is left in place; ex_wreg masking makes it harmless.
                  main_valid_d = 1'b0;
               end else if (accept && (SKID != 0)) begin
                  skid_valid_d = 1'b1;
                  skid_d       = in_pl;
               end
            end
            FULL: begin
               if (drain) begin
                  main_d       = skid_q;
                  skid_valid_d = 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      stall_cnt_d = stall_cnt_q;
      if (main_valid_q && !ex_ready && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // NOTE: sequential state uses non-blocking assignments only; payload flops are
   // reset as well so ex_* read back as zero straight out of reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         main_valid_q <= 1'b0;
         skid_valid_q <= 1'b0;
         main_q       <= '0;
         skid_q       <= '0;
         stall_cnt_q  <= '0;
      end else begin
         main_valid_q <= main_valid_d;
         skid_valid_q <= skid_valid_d;
         main_q       <= main_d;
         skid_q       <= skid_d;
         stall_cnt_q  <= stall_cnt_d;
      end
   end

   assign ex_valid  = main_valid_q;
   assign ex_alusel = main_q.alusel;
   assign ex_aluop  = main_q.aluop;
   assign ex_reg1   = main_q.reg1;
   assign ex_reg2   = main_q.reg2;
   assign ex_wd     = main_q.wd;
   assign ex_wreg   = main_valid_q & main_q.wreg;
   assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// Scoreboard bench for id_ex_pipe: a default build (skid, 16-bit counter) and a
// SKID=0 / CNT_W=4 build share the stimulus; sel picks which one is checked.
module tb_id_ex_pipe;

   typedef logic [80:0] beat_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        flush;
   logic        id_valid;
   logic        ex_ready;
   logic [2:0]  id_alusel;
   logic [7:0]  id_aluop;
   logic [31:0] id_reg1, id_reg2;
   logic [4:0]  id_wd;
   logic        id_wreg;

   logic        a_id_ready, a_ex_valid, a_ex_wreg;
   logic [2:0]  a_ex_alusel;
   logic [7:0]  a_ex_aluop;
   logic [31:0] a_ex_reg1, a_ex_reg2;
   logic [4:0]  a_ex_wd;
   logic [15:0] a_stall_cnt;

   logic        b_id_ready, b_ex_valid, b_ex_wreg;
   logic [2:0]  b_ex_alusel;
   logic [7:0]  b_ex_aluop;
   logic [31:0] b_ex_reg1, b_ex_reg2;
   logic [4:0]  b_ex_wd;
   logic [3:0]  b_stall_cnt;

   bit    sel = 1'b0;
   bit    acc;
   int    checks = 0;
   int    failures = 0;
   int    drained = 0;
   beat_t exp_q[$];

   always #5 clk = ~clk;

   id_ex_pipe u_dut_a (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(a_id_ready),
      .id_alusel(id_alusel), .id_aluop(id_aluop), .id_reg1(id_reg1), .id_reg2(id_reg2),
      .id_wd(id_wd), .id_wreg(id_wreg), .ex_valid(a_ex_valid), .ex_ready(ex_ready),
      .ex_alusel(a_ex_alusel), .ex_aluop(a_ex_aluop), .ex_reg1(a_ex_reg1),
      .ex_reg2(a_ex_reg2), .ex_wd(a_ex_wd), .ex_wreg(a_ex_wreg), .stall_cnt(a_stall_cnt)
   );

   id_ex_pipe #(.SKID(0), .CNT_W(4)) u_dut_b (
      .clk(clk), .rst(rst), .flush(flush), .id_valid(id_valid), .id_ready(b_id_ready),
      .id_alusel(id_alusel), .id_aluop(id_aluop), .id_reg1(id_reg1), .id_reg2(id_reg2),
      .id_wd(id_wd), .id_wreg(id_wreg), .ex_valid(b_ex_valid), .ex_ready(ex_ready),
      .ex_alusel(b_ex_alusel), .ex_aluop(b_ex_aluop), .ex_reg1(b_ex_reg1),
      .ex_reg2(b_ex_reg2), .ex_wd(b_ex_wd), .ex_wreg(b_ex_wreg), .stall_cnt(b_stall_cnt)
   );

   beat_t in_beat, a_beat, b_beat, m_beat;
   logic  m_id_ready, m_ex_valid;

   assign in_beat    = {id_alusel, id_aluop, id_reg1, id_reg2, id_wd, id_wreg};
   assign a_beat     = {a_ex_alusel, a_ex_aluop, a_ex_reg1, a_ex_reg2, a_ex_wd, a_ex_wreg};
   assign b_beat     = {b_ex_alusel, b_ex_aluop, b_ex_reg1, b_ex_reg2, b_ex_wd, b_ex_wreg};
   assign m_beat     = sel ? b_beat : a_beat;
   assign m_id_ready = sel ? b_id_ready : a_id_ready;
   assign m_ex_valid = sel ? b_ex_valid : a_ex_valid;

   task automatic check(input string name, input beat_t act, input beat_t exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   // Monitor: every beat EX consumes must be the oldest outstanding expectation.
   always @(negedge clk) begin
      if (rst && !flush && m_ex_valid && ex_ready) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h expected=none", m_beat);
         end else begin
            check("beat", m_beat, exp_q.pop_front());
            drained++;
         end
      end
   end

   task automatic set_beat(input int k);
      id_alusel = k[2:0];
      id_aluop  = 8'hA0 ^ k[7:0];
      id_reg1   = 32'h10 + k;
      id_reg2   = 32'hBEEF_0000 | k;
      id_wd     = k[4:0];
      id_wreg   = 1'b1;
   endtask

   // One clock: log the handshake at mid-cycle, then return just after the edge.
   task automatic cycle();
      @(negedge clk);
      acc = rst && !flush && id_valid && m_id_ready;
      if (acc) exp_q.push_back(in_beat);
      if (flush) exp_q.delete();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      exp_q.delete();
      #1;
      check("rst_ex_valid", beat_t'(m_ex_valid), 0);
      check("rst_payload", m_beat, 0);
      check("rst_id_ready", beat_t'(m_id_ready), 1);
      check("rst_stall_a", beat_t'(a_stall_cnt), 0);
      check("rst_stall_b", beat_t'(b_stall_cnt), 0);
      @(posedge clk);
      #1;
      rst = 1'b1;
   endtask

   // mode 0: ex_ready low for cycles lo..hi; mode 1: ex_ready toggles 1/0.
   task automatic stream(input int n, input int base, input int mode, input int lo,
                         input int hi);
      int sent = 0;
      int d0   = drained;
      for (int cyc = 0; cyc < 60 && !(sent == n && exp_q.size() == 0); cyc++) begin
         id_valid = (sent < n);
         set_beat(base + sent);
         ex_ready = (mode == 1) ? (cyc % 2 == 0) : !(cyc >= lo && cyc <= hi);
         #1;
         if (mode == 1) begin
            check("comb_id_ready", beat_t'(m_id_ready), beat_t'(!m_ex_valid | ex_ready));
         end else if (cyc <= n) begin
            check("id_ready", beat_t'(m_id_ready), beat_t'(!(cyc >= lo + 1 && cyc <= hi + 1)));
            if (lo > hi && cyc >= 1) check("ex_valid_cont", beat_t'(m_ex_valid), 1);
            if (lo <= hi && cyc == hi + 1) check("skid_extra", beat_t'(sent), beat_t'(lo + 1));
         end
         cycle();
         if (acc) sent++;
      end
      id_valid = 1'b0;
      ex_ready = 1'b1;
      check("stream_sent", beat_t'(sent), beat_t'(n));
      check("stream_drained", beat_t'(drained - d0), beat_t'(n));
   endtask

   initial begin
      int s0;
      rst = 1'b0; flush = 1'b0; id_valid = 1'b0; ex_ready = 1'b1;
      set_beat(0);
      do_reset();

      // Back-to-back streaming, then a three-cycle stall absorbed by the skid slot.
      stream(8, 0, 0, 100, 99);
      check("stall_stream", beat_t'(a_stall_cnt), 0);
      stream(8, 16, 0, 3, 5);
      check("stall_skid", beat_t'(a_stall_cnt), 3);

      // Asynchronous reset in the middle of a cycle while the block is FULL.
      ex_ready = 1'b0; id_valid = 1'b1;
      set_beat(50); cycle();
      set_beat(51); cycle();
      check("full_id_ready", beat_t'(a_id_ready), 0);
      #2;
      do_reset();
      stream(1, 60, 0, 100, 99);

      // Flush while FULL with a beat on the input, then flush in ONE with an accept.
      s0 = a_stall_cnt;
      ex_ready = 1'b0; id_valid = 1'b1;
      set_beat(70); cycle();
      set_beat(71); cycle();
      flush = 1'b1;
      set_beat(72);
      #1;
      check("flush_pre_ready", beat_t'(a_id_ready), 0);
      cycle();
      flush = 1'b0; id_valid = 1'b0;
      #1;
      check("flush_ex_valid", beat_t'(a_ex_valid), 0);
      check("flush_payload", a_beat, 0);
      check("flush_id_ready", beat_t'(a_id_ready), 1);
      check("flush_stall", beat_t'(a_stall_cnt), beat_t'(s0 + 2));
      id_valid = 1'b1;
      set_beat(73); cycle();
      flush = 1'b1;
      set_beat(74); cycle();
      flush = 1'b0; id_valid = 1'b0;
      #1;
      check("flush_one_valid", beat_t'(a_ex_valid), 0);
      stream(2, 80, 0, 100, 99);

      // SKID=0 build: combinational id_ready under a toggling ex_ready.
      sel = 1'b1;
      do_reset();
      stream(8, 100, 1, 0, 0);

      // Counter saturation on the 4-bit build; the 16-bit build keeps counting.
      do_reset();
      ex_ready = 1'b0; id_valid = 1'b1;
      set_beat(120); cycle();
      id_valid = 1'b0;
      repeat (20) cycle();
      check("stall_sat_b", beat_t'(b_stall_cnt), 15);
      check("stall_cnt_a", beat_t'(a_stall_cnt), 20);
      ex_ready = 1'b1;
      cycle(); cycle();
      check("sat_drain", beat_t'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
